// File: rtl/rtc_bus_reader.sv
// Read-back engine for the external RTC on the multiplexed address/data bus:
// issues the 0xF0 buffer-transfer command, reads nine registers, then publishes them atomically.
module rtc_bus_reader #(
  parameter int T_PULSO  = 7,
  parameter int T_ESPERA = 7
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] bus_i,
  output logic [7:0] bus_o,
  output logic       bus_oe,
  output logic       AD_o,
  output logic       RD,
  output logic       WR,
  output logic       CS,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] fecha,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] tseg,
  output logic [7:0] tmin,
  output logic [7:0] thora
);

  typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D} state_t;

  localparam logic [3:0] PULSO_LAST  = 4'(T_PULSO - 1);
  localparam logic [3:0] ESPERA_LAST = 4'(T_ESPERA - 1);
  localparam logic [3:0] LAST_ITEM   = 4'd9;

  state_t     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic [3:0] idx_r, idx_s;
  logic [3:0] sh_idx_s;
  logic       capture_s, publish_s;
  logic       cs_s, wr_s, rd_s, ad_s, oe_s;
  logic [7:0] bus_s;
  logic [7:0] shadow_r [0:8];

  function automatic logic [7:0] item_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    item_addr = 8'hF0;
      4'd1:    item_addr = 8'h21;
      4'd2:    item_addr = 8'h22;
      4'd3:    item_addr = 8'h23;
      4'd4:    item_addr = 8'h24;
      4'd5:    item_addr = 8'h25;
      4'd6:    item_addr = 8'h26;
      4'd7:    item_addr = 8'h41;
      4'd8:    item_addr = 8'h42;
      4'd9:    item_addr = 8'h43;
      default: item_addr = 8'hF0;
    endcase
  endfunction

  // Next state, item index, phase counter and capture/publish strobes.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    capture_s = 1'b0;
    publish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ADDR;
          idx_s   = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (cnt_r == PULSO_LAST) state_s = GAP_A;
        else                     state_s = ADDR;
      end
      GAP_A: begin
        if (cnt_r == ESPERA_LAST) state_s = DATA;
        else                      state_s = GAP_A;
      end
      DATA: begin
        if (cnt_r == PULSO_LAST) begin
          state_s   = GAP_D;
          capture_s = (idx_r != 4'd0);
        end else begin
          state_s = DATA;
        end
      end
      GAP_D: begin
        if (cnt_r != ESPERA_LAST) begin
          state_s = GAP_D;
        end else if (idx_r == LAST_ITEM) begin
          state_s   = IDLE;
          publish_s = 1'b1;
        end else begin
          state_s = ADDR;
          idx_s   = idx_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 4'd0;
      end
    endcase

    if (state_s == IDLE)         cnt_s = 4'd0;
    else if (state_s != state_r) cnt_s = 4'd0;
    else                         cnt_s = cnt_r + 4'd1;

    sh_idx_s = idx_r - 4'd1;
  end

  // Bus and strobe values for the upcoming cycle, decoded from the next state so they register cleanly.
  always_comb begin
    cs_s  = 1'b1;
    wr_s  = 1'b1;
    rd_s  = 1'b1;
    ad_s  = 1'b0;
    oe_s  = 1'b0;
    bus_s = 8'h00;
    case (state_s)
      IDLE: begin
        bus_s = 8'h00;
      end
      ADDR: begin
        cs_s  = 1'b0;
        wr_s  = 1'b0;
        oe_s  = 1'b1;
        bus_s = item_addr(idx_s);
      end
      GAP_A: begin
        oe_s  = 1'b1;
        bus_s = item_addr(idx_s);
      end
      DATA: begin
        cs_s  = 1'b0;
        ad_s  = 1'b1;
        bus_s = item_addr(idx_s);
        // item 0 writes the command byte; everything else is a read with the bus released
        if (idx_s == 4'd0) begin
          wr_s = 1'b0;
          oe_s = 1'b1;
        end else begin
          rd_s = 1'b0;
          oe_s = 1'b0;
        end
      end
      GAP_D: begin
        ad_s  = 1'b1;
        bus_s = item_addr(idx_s);
      end
      default: begin
        bus_s = 8'h00;
      end
    endcase
  end

  // State, registered bus outputs, shadow capture and atomic publish.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= 4'd0;
      CS      <= 1'b1;
      WR      <= 1'b1;
      RD      <= 1'b1;
      AD_o    <= 1'b0;
      bus_oe  <= 1'b0;
      bus_o   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 9; i++) shadow_r[i] <= 8'h00;
      seg     <= 8'h00;
      min     <= 8'h00;
      hora    <= 8'h00;
      fecha   <= 8'h00;
      mes     <= 8'h00;
      anio    <= 8'h00;
      tseg    <= 8'h00;
      tmin    <= 8'h00;
      thora   <= 8'h00;
    end else if (enable) begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      CS      <= cs_s;
      WR      <= wr_s;
      RD      <= rd_s;
      AD_o    <= ad_s;
      bus_oe  <= oe_s;
      bus_o   <= bus_s;
      busy    <= (state_s != IDLE);
      done    <= publish_s;
      if (capture_s) shadow_r[sh_idx_s] <= bus_i;
      if (publish_s) begin
        seg   <= shadow_r[0];
        min   <= shadow_r[1];
        hora  <= shadow_r[2];
        fecha <= shadow_r[3];
        mes   <= shadow_r[4];
        anio  <= shadow_r[5];
        tseg  <= shadow_r[6];
        tmin  <= shadow_r[7];
        thora <= shadow_r[8];
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench for rtc_bus_reader: an RTC bus model answers reads, a vector table drives
// full sweeps, and hand-written sequences cover start-while-busy, atomic publish and reset mid-sweep.
module tb_rtc_bus_reader;

  logic       clk_i = 1'b0;
  logic       reset, enable, start;
  logic [7:0] bus_i, bus_o;
  logic       bus_oe, AD_o, RD, WR, CS, busy, done;
  logic [7:0] seg, min, hora, fecha, mes, anio, tseg, tmin, thora;
  logic [71:0] pub_w;

  rtc_bus_reader #(.T_PULSO(7), .T_ESPERA(7)) dut (
    .clk_i(clk_i), .reset(reset), .enable(enable), .start(start),
    .bus_i(bus_i), .bus_o(bus_o), .bus_oe(bus_oe), .AD_o(AD_o),
    .RD(RD), .WR(WR), .CS(CS), .busy(busy), .done(done),
    .seg(seg), .min(min), .hora(hora), .fecha(fecha), .mes(mes), .anio(anio),
    .tseg(tseg), .tmin(tmin), .thora(thora)
  );

  always #5 clk_i = ~clk_i;

  assign pub_w = {seg, min, hora, fecha, mes, anio, tseg, tmin, thora};

  int checks = 0;
  int passed = 0;

  // RTC model: latches the address phase, answers while RD is low.
  logic [7:0] model [0:8];
  logic [7:0] addr_lat = 8'h00;

  always_comb begin
    bus_i = 8'hEE;
    if (!RD) begin
      case (addr_lat)
        8'h21:   bus_i = model[0];
        8'h22:   bus_i = model[1];
        8'h23:   bus_i = model[2];
        8'h24:   bus_i = model[3];
        8'h25:   bus_i = model[4];
        8'h26:   bus_i = model[5];
        8'h41:   bus_i = model[6];
        8'h42:   bus_i = model[7];
        8'h43:   bus_i = model[8];
        default: bus_i = 8'hEE;
      endcase
    end
  end

  int nwa, nwd, nrd, bad_len, contention, low_len, gap_len;
  logic prev_cs;
  int freeze_bad, pub_bad;
  logic [71:0] pub_prev;

  typedef struct {
    logic [71:0] data;
    logic [71:0] expv;
    int          stall_at;
    int          stall_len;
    int          exp_done;
  } vec_t;
  vec_t vecs [0:2];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  task automatic mon_clear();
    nwa = 0; nwd = 0; nrd = 0; bad_len = 0; contention = 0;
    low_len = 0; gap_len = 0; prev_cs = 1'b1;
  endtask

  task automatic load_model(input logic [71:0] d);
    for (int i = 0; i < 9; i++) model[i] = d[71 - 8*i -: 8];
  endtask

  // Advance one cycle and sample everything at the falling edge.
  task automatic tick();
    @(negedge clk_i);
    if (!CS && !WR && !AD_o) addr_lat = bus_o;
    if (!RD && bus_oe) contention++;
    if (!CS) begin
      if (RD == WR) bad_len++;
      if (prev_cs) begin
        if (!WR && !AD_o) nwa++;
        else if (!WR)     nwd++;
        else if (!RD)     nrd++;
        if (gap_len != 0 && gap_len != 7) bad_len++;
      end
      low_len++;
    end else begin
      if (!prev_cs) begin
        if (low_len != 7) bad_len++;
        gap_len = 0;
      end
      low_len = 0;
      if (busy) gap_len++;
      else      gap_len = 0;
    end
    prev_cs = CS;
  endtask

  // One sweep: start is sampled at the next edge (E0); k counts edges after E0.
  task automatic run_sweep(input int stall_at, input int stall_len, input int chg_at,
                           input logic [71:0] chg_data, input int start_at, output int done_k);
    logic [13:0] snap;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_cycle", {done, busy, CS, WR, RD, AD_o, bus_oe, bus_o},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0});
    done_k = -1;
    snap = '0;
    for (int k = 1; k <= 600; k++) begin
      if (stall_at > 0 && k == stall_at) begin
        enable = 1'b0;
        snap = {busy, CS, WR, RD, AD_o, bus_oe, bus_o};
      end
      if (stall_at > 0 && k == stall_at + stall_len) enable = 1'b1;
      if (k == chg_at) load_model(chg_data);
      start = (k == start_at);
      tick();
      if (stall_at > 0 && k >= stall_at && k < stall_at + stall_len &&
          {busy, CS, WR, RD, AD_o, bus_oe, bus_o} !== snap) freeze_bad++;
      if (done) begin
        done_k = k;
        break;
      end
      if (pub_w !== pub_prev) pub_bad++;
    end
    start = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    int done_k;
    int busy_cnt;

    vecs[0] = '{72'h45_30_12_26_04_16_59_58_23, 72'h45_30_12_26_04_16_59_58_23, 0,   0,  280};
    vecs[1] = '{72'h00_59_23_31_12_99_00_01_02, 72'h00_59_23_31_12_99_00_01_02, 60,  50, 330};
    vecs[2] = '{72'h59_00_08_01_01_00_30_15_00, 72'h59_00_08_01_01_00_30_15_00, 150, 3,  283};

    reset = 1'b1; enable = 1'b1; start = 1'b0;
    load_model(72'h0);
    mon_clear();
    repeat (3) tick();
    check("reset_strobes", {CS, RD, WR, AD_o, bus_oe, busy, done}, 7'b1110000);
    check("reset_bus", bus_o, 8'h00);
    check("reset_pub", pub_w, 72'h0);
    reset = 1'b0;
    tick();

    // Table: back-to-back sweeps, each starting the cycle right after the previous done.
    for (int i = 0; i < 3; i++) begin
      load_model(vecs[i].data);
      mon_clear();
      pub_prev = pub_w; pub_bad = 0; freeze_bad = 0;
      run_sweep(vecs[i].stall_at, vecs[i].stall_len, -1, 72'h0, -1, done_k);
      check($sformatf("v%0d_done_cycle", i), done_k, vecs[i].exp_done);
      check($sformatf("v%0d_outputs", i), pub_w, vecs[i].expv);
      check($sformatf("v%0d_no_early_pub", i), pub_bad, 0);
      check($sformatf("v%0d_oe_during_rd", i), contention, 0);
      if (vecs[i].stall_at > 0) check($sformatf("v%0d_frozen", i), freeze_bad, 0);
      if (i == 0) begin
        check("wr_addr_pulses", nwa, 10);
        check("wr_data_pulses", nwd, 1);
        check("rd_pulses", nrd, 9);
        check("pulse_gap_len", bad_len, 0);
      end
    end

    // Model changes mid-sweep (items 1-2 already read) and a start pulse while busy.
    tick();
    check("done_falls", {done, busy}, 2'b00);
    pub_prev = pub_w; pub_bad = 0;
    load_model(72'h11_22_33_44_55_66_77_88_99);
    run_sweep(0, 0, 100, 72'hA1_A2_A3_A4_A5_A6_A7_A8_A9, 100, done_k);
    check("atomic_done_cycle", done_k, 280);
    check("atomic_outputs", pub_w, 72'h11_22_A3_A4_A5_A6_A7_A8_A9);
    check("atomic_no_early_pub", pub_bad, 0);
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (busy || done) busy_cnt++;
    end
    check("no_second_sweep", busy_cnt, 0);

    // Reset during an RD pulse of item 5.
    load_model(vecs[0].data);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 155; k++) tick();
    check("rd_low_before_reset", {CS, RD, AD_o}, 3'b001);
    reset = 1'b1;
    tick();
    check("midreset_strobes", {CS, RD, WR, AD_o, bus_oe, busy, done}, 7'b1110000);
    check("midreset_pub", pub_w, 72'h0);
    reset = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (busy || done) busy_cnt++;
    end
    check("midreset_idle", busy_cnt, 0);
    pub_prev = pub_w; pub_bad = 0;
    run_sweep(0, 0, -1, 72'h0, -1, done_k);
    check("after_reset_done_cycle", done_k, 280);
    check("after_reset_outputs", pub_w, 72'h45_30_12_26_04_16_59_58_23);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
